// File: rtl/instr_loader_pkg.sv
// Shared defaults, program-entry layout and FSM state encoding for the instruction loader.
package instr_loader_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_ADDR_W  = 4;
  localparam int DEF_HOPS_W  = 4;
  localparam int DEF_DEPTH   = 64;
  localparam int DEF_TIMEOUT = 1024;

  typedef struct packed {
    logic [DEF_HOPS_W-1:0] hops;
    logic [DEF_ADDR_W-1:0] addr;
    logic [DEF_DATA_W-1:0] data;
  } instr_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CALL,
    ST_WAIT_RET,
    ST_DONE
  } state_t;

endpackage

// File: rtl/instr_loader_if.sv
// Program-load, run-control and row-instruction signals between the loader, its host and the fabric row.
interface instr_loader_if
  import instr_loader_pkg::*;
#(
  parameter int INSTR_DATA_WIDTH = DEF_DATA_W,
  parameter int INSTR_ADDR_WIDTH = DEF_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = DEF_HOPS_W,
  parameter int DEPTH            = DEF_DEPTH
);
  localparam int LEN_WIDTH = $clog2(DEPTH + 1);
  localparam int ENTRY_W   = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;

  logic                        prog_wr_en;
  logic [$clog2(DEPTH)-1:0]    prog_wr_addr;
  logic [ENTRY_W-1:0]          prog_wr_data;
  logic                        start;
  logic [LEN_WIDTH-1:0]        prog_len;
  logic                        busy;
  logic                        done;
  logic                        error;
  logic [INSTR_DATA_WIDTH-1:0] instr_data_out;
  logic [INSTR_ADDR_WIDTH-1:0] instr_addr_out;
  logic [INSTR_HOPS_WIDTH-1:0] instr_hops_out;
  logic                        instr_en_out;
  logic                        call;
  logic                        ret;

  modport slave (
    input  prog_wr_en, prog_wr_addr, prog_wr_data, start, prog_len, ret,
    output busy, done, error, instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call
  );

  modport master (
    output prog_wr_en, prog_wr_addr, prog_wr_data, start, prog_len, ret,
    input  busy, done, error, instr_data_out, instr_addr_out, instr_hops_out, instr_en_out, call
  );

endinterface

// File: rtl/instr_loader_mem.sv
// Program buffer: one write port, one registered read port with write-first forwarding on address collision.
module instr_loader_mem #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
  end

  // A run starting in the same cycle as a write to entry 0 must see the new word.
  always_ff @(posedge clk) begin
    r_rdata <= (i_we && (i_waddr == i_raddr)) ? i_wdata : r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: streams the stored program into one fabric row, pulses call, then waits for ret.
// Define INSTR_LOADER_TIMEOUT_EN to add the ret watchdog and the sticky error flag.
module instr_loader
  import instr_loader_pkg::*;
#(
  parameter int INSTR_DATA_WIDTH = DEF_DATA_W,
  parameter int INSTR_ADDR_WIDTH = DEF_ADDR_W,
  parameter int INSTR_HOPS_WIDTH = DEF_HOPS_W,
  parameter int DEPTH            = DEF_DEPTH,
  parameter int TIMEOUT_CYCLES   = DEF_TIMEOUT
) (
  input logic          clk,
  input logic          rst,
  instr_loader_if.slave bus
);

  localparam int AW        = $clog2(DEPTH);
  localparam int LEN_WIDTH = $clog2(DEPTH + 1);
  localparam int DW        = INSTR_DATA_WIDTH;
  localparam int EW        = INSTR_HOPS_WIDTH + INSTR_ADDR_WIDTH + INSTR_DATA_WIDTH;
  localparam logic [LEN_WIDTH-1:0] LP_DEPTH = LEN_WIDTH'(DEPTH);

  state_t                      r_state, w_next;
  logic [LEN_WIDTH-1:0]        r_len, r_cnt, w_len_clip;
  logic                        w_start_acc, w_we, w_issue, w_timeout;
  logic [AW-1:0]               w_raddr;
  logic [EW-1:0]               w_rdata;
  logic                        r_en;
  logic [INSTR_DATA_WIDTH-1:0] r_data;
  logic [INSTR_ADDR_WIDTH-1:0] r_addr;
  logic [INSTR_HOPS_WIDTH-1:0] r_hops;

  assign w_len_clip  = (bus.prog_len > LP_DEPTH) ? LP_DEPTH : bus.prog_len;
  assign w_start_acc = (r_state == ST_IDLE) && bus.start;
  assign w_we        = (r_state == ST_IDLE) && bus.prog_wr_en;
  assign w_issue     = (r_state == ST_ISSUE) && (r_cnt != r_len);
  // Read one entry ahead: the word for r_cnt is already in the read register.
  assign w_raddr     = (r_state == ST_ISSUE) ? (AW'(r_cnt) + 1'b1) : '0;

  instr_loader_mem #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_we),
    .i_waddr (bus.prog_wr_addr),
    .i_wdata (bus.prog_wr_data),
    .i_raddr (w_raddr),
    .o_rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (bus.start) w_next = (w_len_clip == '0) ? ST_CALL : ST_ISSUE;
      ST_ISSUE:    if (r_cnt == r_len) w_next = ST_CALL;
      ST_CALL:     w_next = ST_WAIT_RET;
      ST_WAIT_RET: if (bus.ret || w_timeout) w_next = ST_DONE;
      ST_DONE:     w_next = ST_IDLE;
      default:     w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_len <= '0;
      r_cnt <= '0;
    end else if (w_start_acc) begin
      r_len <= w_len_clip;
      r_cnt <= '0;
    end else if (w_issue) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_data <= '0;
      r_addr <= '0;
      r_hops <= '0;
    end else begin
      r_en   <= w_issue;
      r_data <= w_issue ? w_rdata[DW-1:0] : '0;
      r_addr <= w_issue ? w_rdata[DW +: INSTR_ADDR_WIDTH] : '0;
      r_hops <= w_issue ? w_rdata[EW-1 -: INSTR_HOPS_WIDTH] : '0;
    end
  end

`ifdef INSTR_LOADER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_to;
  logic          r_error;

  assign w_timeout = (r_to == TW'(TIMEOUT_CYCLES - 1));

  // error survives DONE/IDLE so the host can read it after the run ends.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to    <= '0;
      r_error <= 1'b0;
    end else begin
      r_to <= (r_state == ST_WAIT_RET) ? r_to + 1'b1 : '0;
      if (w_start_acc)
        r_error <= 1'b0;
      else if ((r_state == ST_WAIT_RET) && !bus.ret && w_timeout)
        r_error <= 1'b1;
    end
  end

  assign bus.error = r_error;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign w_timeout      = 1'b0;
  assign bus.error      = 1'b0;
`endif

  assign bus.busy           = (r_state != ST_IDLE);
  assign bus.done           = (r_state == ST_DONE);
  assign bus.call           = (r_state == ST_CALL);
  assign bus.instr_en_out   = r_en;
  assign bus.instr_data_out = r_data;
  assign bus.instr_addr_out = r_addr;
  assign bus.instr_hops_out = r_hops;

endmodule

// File: doc/instr_loader.md
INSTR_LOADER -- requirements
Module: instr_loader

Interface
REQ-001 SHALL have parameter INSTR_DATA_WIDTH, default 32, instruction payload width.
REQ-002 SHALL have parameter INSTR_ADDR_WIDTH, default 4, in-cell resource address width.
REQ-003 SHALL have parameter INSTR_HOPS_WIDTH, default 4, column hop-count width.
REQ-004 SHALL have parameter DEPTH, default 64, program buffer entries; LEN_WIDTH = $clog2(DEPTH+1).
REQ-005 SHALL have parameter TIMEOUT_CYCLES, default 1024, ret watchdog limit (used only under REQ-029).
REQ-006 SHALL have port clk, input, 1, sole clock, rising edge.
REQ-007 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-008 SHALL have ports prog_wr_en/prog_wr_addr/prog_wr_data, inputs, 1/$clog2(DEPTH)/(HOPS+ADDR+DATA), program-buffer write; data packed {hops, addr, data}.
REQ-009 SHALL have ports start (input, 1, run pulse) and prog_len (input, LEN_WIDTH, entries to issue).
REQ-010 SHALL have ports busy, done, error, outputs, 1 each, status.
REQ-011 SHALL have ports instr_data_out/instr_addr_out/instr_hops_out/instr_en_out, outputs, matching widths/1, feed one fabric row's instruction chain input.
REQ-012 SHALL have ports call (output, 1, row start) and ret (input, 1, row completion from fabric).

Function
REQ-013 SHALL implement FSM states IDLE, ISSUE, CALL, WAIT_RET, DONE.
REQ-014 IDLE: start sampled high SHALL latch min(prog_len, DEPTH) and go to ISSUE; if latched length is 0, go directly to CALL.
REQ-015 Buffer SHALL have 1-cycle synchronous read; instr_en_out SHALL be high for exactly latched-length consecutive cycles, first high 2 cycles after the start edge, entries in index order 0..len-1.
REQ-016 All instr_*_out SHALL be registered; instr_data/addr/hops_out SHALL be 0 whenever instr_en_out is 0.
REQ-017 call SHALL pulse high exactly one cycle, the cycle after the last instr_en_out (or 1 cycle after start for length 0), then enter WAIT_RET.
REQ-018 WAIT_RET SHALL exit to DONE on the first cycle ret is sampled high; ret outside WAIT_RET SHALL be ignored.
REQ-019 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-020 busy SHALL be 1 in every state except IDLE.
REQ-021 start while busy SHALL be ignored.
REQ-022 prog_wr_en while busy SHALL be ignored; when idle, write completes in one cycle and is readable by a start in the next cycle.
REQ-023 Write and start in the same idle cycle: write SHALL take effect before the run reads that entry.

Reset
REQ-024 On rst assertion all outputs SHALL go to 0 and FSM to IDLE asynchronously, including mid-ISSUE or mid-WAIT_RET.
REQ-025 Program buffer contents SHALL NOT be cleared by reset.
REQ-026 After rst deassertion, first start SHALL be accepted on the first clk edge.

Configuration
REQ-027 Macro INSTR_LOADER_TIMEOUT_EN SHALL gate the ret watchdog.
REQ-028 Without it: no counter; error tied 0; WAIT_RET waits indefinitely.
REQ-029 With it: counter counts WAIT_RET cycles; reaching TIMEOUT_CYCLES without ret SHALL go to DONE and set error=1, sticky until next accepted start or reset.

Structure
REQ-030 Package instr_loader_pkg SHALL hold the width defaults, packed entry struct {hops, addr, data} and FSM state enum.
REQ-031 Sub-module instr_loader_mem SHALL implement the DEPTH-entry 1-write/1-sync-read buffer.

Verification
REQ-032 Write 3 entries, start with prog_len=3 -> instr_en_out high cycles 2-4 with entries 0,1,2; call at cycle 5; ret at cycle 8 -> done at cycle 9.
REQ-033 prog_len=0, start -> no instr_en_out, call at cycle 1, done one cycle after ret.
REQ-034 prog_len=DEPTH+5 -> exactly DEPTH instr_en_out cycles.
REQ-035 start and prog_wr_en pulsed during ISSUE -> no restart, buffer unchanged.
REQ-036 rst asserted while issuing entry 2 of 5 -> all outputs 0 immediately, busy=0; new start reissues from entry 0.
REQ-037 With INSTR_LOADER_TIMEOUT_EN, TIMEOUT_CYCLES=16, ret held 0 -> done and error=1 16 cycles after entering WAIT_RET; error clears on next start.
